axis_insert_header: RTL and testbench

Streaming AXI-Stream block that prepends a per-packet header of 1..DATA_BYTE_WD bytes to an input packet and repacks the result into full-width output beats. It sits between a packet source and a downstream AXI-Stream sink, with a separate header channel. The header's bytes come out first, then the packet bytes, byte-contiguous, with only the final output beat partial.

---
 rtl/axis_insert_header_pkg.sv | 35 +++
 rtl/axis_insert_header_if.sv | 41 ++++
 rtl/axis_insert_header.sv | 136 +++++++++++++
 tb/tb_axis_insert_header.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_insert_header_pkg.sv
// Shared types and byte-count helpers for axis_insert_header.
// Helpers take the live byte count so they work for any DATA_WD up to MAX_BYTES*8.
package axis_insert_header_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  // keep is right-aligned in the low nb bits; counts contiguous ones from bit nb-1 down
  function automatic logic [7:0] lead_ones(input logic [MAX_BYTES-1:0] keep, input int nb);
    logic run;
    lead_ones = '0;
    run       = 1'b1;
    for (int i = MAX_BYTES-1; i >= 0; i--) begin
      if (i < nb) begin
        run = run & keep[i];
        if (run) lead_ones = lead_ones + 8'd1;
      end
    end
  endfunction

  function automatic logic [MAX_BYTES-1:0] cnt2keep(input logic [7:0] cnt, input int nb);
    for (int i = 0; i < MAX_BYTES; i++)
      cnt2keep[i] = (i < nb) && (i >= nb - int'(cnt));
  endfunction

  function automatic logic [7:0] cnt_decode(input logic [7:0] code, input int nb);
    return (code == 8'd0) ? 8'(nb) : code;
  endfunction

endpackage

// File: rtl/axis_insert_header_if.sv
// Data, header and output channels of axis_insert_header.
// slave is the block's view; master is the source/sink view.
interface axis_insert_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD/8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic                    ready_in;
  logic                    last_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;

  logic                    valid_insert;
  logic                    ready_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;

  logic                    valid_out;
  logic                    ready_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;

  modport slave (
    input  valid_in, last_in, data_in, keep_in,
    input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_out,
    output ready_in, ready_insert,
    output valid_out, data_out, keep_out, last_out
  );

  modport master (
    output valid_in, last_in, data_in, keep_in,
    output valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_out,
    input  ready_in, ready_insert,
    input  valid_out, data_out, keep_out, last_out
  );
endinterface

// File: rtl/axis_insert_header.sv
// Prepends a 1..DATA_BYTE_WD byte header to each packet and repacks to full beats.
// The residual register carries the bytes that spill over into the next output beat.
module axis_insert_header
  import axis_insert_header_pkg::*;
#(
  parameter int DATA_WD = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_insert_header_if.slave  bus
);

  localparam int DBW = DATA_WD/8;

  state_e               state_q, state_d;
  logic [DATA_WD-1:0]   res_q, res_d;
  logic [7:0]           n_q, n_d;
  logic [7:0]           rem_q, rem_d;
  logic                 vout_q, vout_d;
  logic [DATA_WD-1:0]   dout_q, dout_d;
  logic [DBW-1:0]       keep_q, keep_d;
  logic                 last_q, last_d;

  logic                 slot_free, in_fire, hdr_fire;
  logic [DATA_WD-1:0]   src, merged;
  logic [2*DATA_WD-1:0] wide;
  logic [7:0]           m_cnt, total;
  logic [MAX_BYTES-1:0] kw;
  logic                 unused_keep_insert;

  function automatic logic [DATA_WD-1:0] keep2mask(input logic [DBW-1:0] k);
    for (int b = 0; b < DBW; b++) keep2mask[8*b +: 8] = {8{k[b]}};
  endfunction

  assign unused_keep_insert = ^bus.keep_insert;

  assign slot_free        = !vout_q || bus.ready_out;
  assign bus.ready_in     = (state_q == ST_STREAM) && slot_free;
  assign bus.ready_insert = rst_n && (state_q == ST_IDLE);
  assign in_fire          = bus.valid_in && bus.ready_in;
  assign hdr_fire         = bus.valid_insert && bus.ready_insert;

  // In FLUSH only the residual remains; zero the incoming half so the same shifter drains it
  assign src  = (state_q == ST_FLUSH) ? '0 : bus.data_in;
  assign wide = {res_q, src};

  always_comb begin
    merged = '0;
    for (int n = 1; n <= DBW; n++)
      if (n_q == 8'(n)) merged = wide[8*(DBW+n)-1 -: DATA_WD];
  end

  assign m_cnt = lead_ones(MAX_BYTES'(bus.keep_in), DBW);
  assign total = n_q + m_cnt;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    n_d     = n_q;
    rem_d   = rem_q;
    vout_d  = vout_q && !bus.ready_out;
    dout_d  = dout_q;
    keep_d  = keep_q;
    last_d  = last_q;
    kw      = '0;
    case (state_q)
      ST_IDLE: begin
        if (hdr_fire) begin
          res_d   = bus.data_insert;
          n_d     = cnt_decode(8'(bus.byte_insert_cnt), DBW);
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (in_fire) begin
          vout_d = 1'b1;
          res_d  = bus.data_in;
          dout_d = merged;
          keep_d = '1;
          last_d = 1'b0;
          if (bus.last_in) begin
            if (total <= 8'(DBW)) begin
              kw      = cnt2keep(total, DBW);
              keep_d  = kw[DBW-1:0];
              dout_d  = merged & keep2mask(kw[DBW-1:0]);
              last_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              rem_d   = total - 8'(DBW);
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          kw      = cnt2keep(rem_q, DBW);
          vout_d  = 1'b1;
          keep_d  = kw[DBW-1:0];
          dout_d  = merged & keep2mask(kw[DBW-1:0]);
          last_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign bus.valid_out = vout_q;
  assign bus.data_out  = dout_q;
  assign bus.keep_out  = keep_q;
  assign bus.last_out  = last_q;

endmodule

// File: tb/tb_axis_insert_header.sv
// Randomized bench for axis_insert_header against a byte-queue reference model.
module tb_axis_insert_header;

  logic clk, rst_n;
  int   n_tot, n_bad;
  int   rdy_mode;
  bit   bubble_en;

  typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  beat_t       exp_q[$];
  logic [31:0] pd[32];
  logic [3:0]  pk[32];

  axis_insert_header_if #(.DATA_WD(32)) bus();

  axis_insert_header #(.DATA_WD(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lead(input logic [3:0] k);
    int  c;
    bit  run;
    c   = 0;
    run = 1;
    for (int i = 3; i >= 0; i--) begin
      run = run && k[i];
      if (run) c++;
    end
    return c;
  endfunction

  // Reference: header bytes then packet bytes, cut into 4-byte beats, last one partial
  task automatic model(input int n, input logic [31:0] hdr, input int nb);
    logic [7:0] bq[$];
    for (int i = 0; i < n; i++) bq.push_back(hdr[8*(n-1-i) +: 8]);
    for (int b = 0; b < nb; b++) begin
      int m;
      m = (b == nb-1) ? lead(pk[b]) : 4;
      for (int j = 0; j < m; j++) bq.push_back(pd[b][31-8*j -: 8]);
    end
    while (bq.size() > 0) begin
      beat_t e;
      int    c;
      c   = (bq.size() > 4) ? 4 : bq.size();
      e.d = '0;
      for (int j = 0; j < c; j++) e.d[31-8*j -: 8] = bq.pop_front();
      e.k = 4'(4'hF << (4-c));
      e.l = (bq.size() == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drv_hdr(input logic [31:0] d, input int n);
    int to;
    bus.valid_insert    = 1'b1;
    bus.data_insert     = d;
    bus.keep_insert     = 4'($urandom);
    bus.byte_insert_cnt = 2'(n);
    to = 0;
    do begin @(negedge clk); to++; end while (!bus.ready_insert && to < 500);
    chk("hdr_hs", bus.ready_insert, 1);
    @(posedge clk); #1;
    bus.valid_insert = 1'b0;
  endtask

  task automatic drv_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int to;
    if (bubble_en) begin
      bus.valid_in = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = k;
    bus.last_in  = l;
    to = 0;
    do begin @(negedge clk); to++; end while (!bus.ready_in && to < 500);
    chk("beat_hs", bus.ready_in, 1);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic pkt(input int n, input logic [31:0] hdr, input int nb);
    model(n, hdr, nb);
    fork
      drv_hdr(hdr, n);
      begin
        for (int b = 0; b < nb; b++) drv_beat(pd[b], pk[b], b == nb-1);
        chk("rdy_in_after_last", bus.ready_in, 0);
      end
    join
  endtask

  task automatic wait_drain();
    int to;
    to = 0;
    while ((exp_q.size() != 0 || bus.valid_out) && to < 2000) begin
      @(negedge clk);
      to++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.ready_out = 1'b1;
        2:       bus.ready_out = 1'b0;
        default: bus.ready_out = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Scoreboard plus hold-while-stalled checks
  initial begin
    logic        stall, hl;
    logic [31:0] hd;
    logic [3:0]  hk;
    beat_t       e;
    stall = 0;
    hd = '0; hk = '0; hl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 0;
      else begin
        if (stall) begin
          chk("hold_valid", bus.valid_out, 1);
          chk("hold_data", bus.data_out, hd);
          chk("hold_keep", bus.keep_out, hk);
          chk("hold_last", bus.last_out, hl);
        end
        if (bus.valid_out && bus.ready_out) begin
          if (exp_q.size() == 0) chk("extra_beat", bus.data_out, 0);
          else begin
            e = exp_q.pop_front();
            chk("data", bus.data_out, e.d);
            chk("keep", bus.keep_out, e.k);
            chk("last", bus.last_out, e.l);
          end
        end
        stall = bus.valid_out && !bus.ready_out;
        hd = bus.data_out; hk = bus.keep_out; hl = bus.last_out;
      end
    end
  end

  initial begin
    int n, nb;
    n_tot = 0; n_bad = 0;
    rdy_mode = 0; bubble_en = 0;
    rst_n = 1'b0;
    bus.valid_in = 0; bus.last_in = 0; bus.data_in = '0; bus.keep_in = '0;
    bus.valid_insert = 0; bus.data_insert = '0; bus.keep_insert = '0;
    bus.byte_insert_cnt = '0; bus.ready_out = 0;

    repeat (3) @(negedge clk);
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_keep_out", bus.keep_out, 0);
    chk("rst_last_out", bus.last_out, 0);
    chk("rst_ready_in", bus.ready_in, 0);
    chk("rst_ready_insert", bus.ready_insert, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_insert", bus.ready_insert, 1);
    chk("idle_ready_in", bus.ready_in, 0);
    @(posedge clk); #1;

    pd[0] = 32'h11223344; pk[0] = 4'hF;
    pd[1] = 32'h55667788; pk[1] = 4'hF;
    pkt(2, 32'hAABBCCDD, 2);
    wait_drain();

    pd[0] = 32'h11223344; pk[0] = 4'h8;
    pkt(3, 32'h00AABBCC, 1);
    wait_drain();
    chk("idle_after_single", bus.ready_insert, 1);

    pd[0] = 32'h01020304; pk[0] = 4'hE;
    pkt(4, 32'hDEADBEEF, 1);
    wait_drain();

    // Data offered before any header must wait
    bus.valid_in = 1'b1; bus.data_in = 32'hA1B2C3D4; bus.keep_in = 4'hF; bus.last_in = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("early_ready_in", bus.ready_in, 0);
      chk("early_valid_out", bus.valid_out, 0);
    end
    @(posedge clk); #1;
    pd[0] = 32'hA1B2C3D4; pk[0] = 4'hF;
    pkt(1, $urandom, 1);
    wait_drain();

    rdy_mode = 1;
    for (int b = 0; b < 16; b++) begin pd[b] = $urandom; pk[b] = 4'($urandom); end
    pk[15] = 4'hC;
    pkt(3, $urandom, 16);
    wait_drain();

    bubble_en = 1;
    for (int p = 0; p < 30; p++) begin
      n  = $urandom_range(1, 4);
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin pd[b] = $urandom; pk[b] = 4'($urandom); end
      pkt(n, $urandom, nb);
    end
    wait_drain();

    // Reset in the middle of a stalled packet
    bubble_en = 0;
    rdy_mode  = 2;
    @(posedge clk); #1;
    drv_hdr(32'h12345678, 2);
    drv_beat(32'h9ABCDEF0, 4'hF, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", bus.valid_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_out", bus.valid_out, 0);
    chk("mid_rst_data_out", bus.data_out, 0);
    chk("mid_rst_keep_out", bus.keep_out, 0);
    chk("mid_rst_last_out", bus.last_out, 0);
    chk("mid_rst_ready_in", bus.ready_in, 0);
    chk("mid_rst_ready_insert", bus.ready_insert, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 1;
    @(posedge clk); #1;
    pd[0] = $urandom; pk[0] = 4'hF;
    pd[1] = $urandom; pk[1] = 4'hE;
    pkt(3, $urandom, 2);
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
